instr_fetch_queue: RTL

Parametrised instruction register stage that replaces the single-entry instruction latch between instruction memory and the control/decode logic. It buffers up to DEPTH fetched instruction words together with their PC, and presents the oldest entry to decode as pre-split MIPS fields (Op, rs, rt, rd, shamt, Funct, imm, j_imm). Flow is valid/ready on both sides, and a flush input discards all buffered words on branch or jump redirect.

---
 rtl/instr_fetch_queue.sv | 114 +++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {instr, pc} feeding decode as split MIPS fields.
// Latency: a word pushed at edge N is the head after edge N (no fall-through); one push + one pop per cycle.
// Backpressure: in_ready drops at full (no same-cycle bypass on pop); flush discards everything, including the offered word.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       Op,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       Funct,
  output logic [15:0]      imm,
  output logic [25:0]      j_imm,
  output logic [PC_W-1:0]  out_pc,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage is deliberately left unreset; the count==0 forcing hides stale contents.
  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [PC_W-1:0] head_pc;

  // in_ready is qualified by reset so nothing is accepted while reset is held.
  assign in_ready  = reset && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Next pointers/occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the offered word into the tail slot; a flushed word is dropped.
  always_ff @(posedge CLK) begin
    if (push && !flush) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

  // Head entry, forced to zero when the queue is empty.
  always_comb begin
    head_instr = '0;
    head_pc    = '0;
    if (out_valid) begin
      head_instr = instr_mem[rd_ptr_q];
      head_pc    = pc_mem[rd_ptr_q];
    end
  end

  assign Op     = head_instr[31:26];
  assign rs     = head_instr[25:21];
  assign rt     = head_instr[20:16];
  assign rd     = head_instr[15:11];
  assign shamt  = head_instr[10:6];
  assign Funct  = head_instr[5:0];
  assign imm    = head_instr[15:0];
  assign j_imm  = head_instr[25:0];
  assign out_pc = head_pc;

endmodule
